mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller that consumes the EX/MEM pipeline register outputs and drives a variable-latency, done-handshake data memory. It issues one read or write per instruction, holds the request until the memory signals completion, and asserts `stall_out` to freeze the EX/MEM register and upstream stages while the access is outstanding. It delivers load data to the MEM/WB register in the completion cycle and flags misaligned, conflicting and timed-out accesses.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum BUSY wait cycles before forced completion (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_in`  in  1  load request (EX/MEM `mem_to_reg_out`).
- `wr_in`  in  1  store request (EX/MEM `mem_write_out`).
- `addr_in`  in  16  byte address (EX/MEM `result_out`).
- `wdata_in`  in  16  store data (EX/MEM `B_out`).
- `adv_in`  in  1  pipeline advance this cycle (EX/MEM enable); must not depend combinationally on anything except `stall_out` and external hazards.
- `mem_done`  in  1  memory completion strobe.
- `mem_data_in`  in  16  read data, valid when `mem_done`=1.
- `mem_rd`  out  1  memory read request, level.
- `mem_wr`  out  1  memory write request, level.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `stall_out`  out  1  access outstanding; freeze upstream.
- `rdata_out`  out  16  load data to MEM/WB.
- `err_out`  out  1  sticky error flag.
- `stall_cnt`  out  16  saturating count of stall cycles.

## Operation
- `req` = `rd_in | wr_in`. `bad` = (`rd_in & wr_in`) | (`req & addr_in[0]`).
- States: IDLE, BUSY, DONE.
- IDLE, no `req`: all outputs inactive; the state holds.
- IDLE, `req & bad`: no memory request is issued and `stall_out`=0. This is a completion cycle. At the edge, `err_out` is set and `data_q` becomes FFFF.
- IDLE, `req & ~bad`:
  - Drive `mem_rd`/`mem_wr` combinationally with `mem_addr`=`addr_in` and `mem_wdata`=`wdata_in`.
  - Latch `addr_q`, `wdata_q` and the op.
  - If `mem_done`, this is a completion cycle. Otherwise `stall_out`=1, the next state is BUSY, and `wait_cnt` is set to 1.
- BUSY:
  - Hold `mem_rd`/`mem_wr` with `addr_q`/`wdata_q`.
  - `mem_done`=1 makes this a completion cycle.
  - Otherwise, if `wait_cnt`==`TIMEOUT`, this is a forced completion: requests are deasserted, `rdata_out`=FFFF, and at the edge `err_out` is set and `data_q` becomes FFFF.
  - Otherwise `stall_out`=1 and `wait_cnt` increments.
- Completion cycle:
  - `stall_out`=0.
  - For a read with `mem_done`, `rdata_out`=`mem_data_in` combinationally and `data_q` captures it. A write leaves `data_q` unchanged.
  - Next state is IDLE if `adv_in`, else DONE.
- DONE: no request, `stall_out`=0, `rdata_out`=`data_q`. Go to IDLE on `adv_in`. This state prevents re-issue while the pipeline is held by another hazard.
- `rdata_out`=`data_q` in all non-completion cycles.
- `stall_cnt` increments at each edge where `stall_out`=1 and saturates at FFFF.
- `err_out` stays set until `rst`.

## Timing
- Reset values: state IDLE; `data_q`, `addr_q`, `wdata_q`, `wait_cnt` and `stall_cnt` 0; `err_out` 0.
- While `rst`=1, `mem_rd`, `mem_wr` and `stall_out` are forced to 0 combinationally.
- Reset during BUSY abandons the access; the memory sees the request drop in the reset cycle.
- Zero-wait memory (`mem_done` in the issue cycle): 0 stall cycles, single-cycle stage.
- `mem_done` k cycles after the issue cycle: `stall_out` is high for exactly k cycles, and `rdata_out` is valid in the k-th cycle after issue.
- Timeout: `stall_out` is high for `TIMEOUT` cycles, and the forced completion occurs in the next cycle.
- `mem_done` and `wait_cnt`==`TIMEOUT` in the same cycle: normal completion, no error.
- `mem_done` outside IDLE-with-request or BUSY is ignored.

## Test plan
- Read, `addr_in`=0x0010, `mem_done` in the issue cycle: `stall_out` never rises; `rdata_out`=`mem_data_in`=0xBEEF in that cycle; `stall_cnt`=0.
- Write, `addr_in`=0x0020, `wdata_in`=0x1234, `mem_done` 3 cycles later: `stall_out` high for 3 cycles; `mem_wr`/`mem_addr`/`mem_wdata` held stable for 4 cycles; `stall_cnt`=3.
- Read with `addr_in`=0x0011: no `mem_rd`; `err_out`=1 from the next cycle; `rdata_out`=FFFF. With `rd_in`=`wr_in`=1, same result.
- `TIMEOUT`=4 with `mem_done` never asserted: 4 stall cycles; forced completion in cycle 5 with `rdata_out`=FFFF; `err_out`=1.
- Read completes with `adv_in`=0 for 2 more cycles: state DONE; no second `mem_rd`; `rdata_out` holds the read value until `adv_in`=1.
- `rst` asserted in the second BUSY cycle: `mem_rd`=0 that cycle; next cycle is IDLE with all counters and `err_out` cleared.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller. Takes the EX/MEM pipeline register outputs,
// issues one read or write per instruction to a variable-latency data memory
// with a done handshake, and holds the request until the memory completes.
// While an access is outstanding, stall_out freezes the EX/MEM register and
// the upstream stages. Load data goes to MEM/WB in the completion cycle.
// Misaligned, conflicting (read and write together) and timed-out accesses
// raise a sticky error and return FFFF as load data.
//
// Parameters:
//   TIMEOUT      maximum BUSY wait cycles before a forced completion (>= 2)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   rd_in        load request (EX/MEM mem_to_reg_out)
//   wr_in        store request (EX/MEM mem_write_out)
//   addr_in      byte address (EX/MEM result_out)
//   wdata_in     store data (EX/MEM B_out)
//   adv_in       pipeline advance this cycle (EX/MEM enable)
//   mem_done     memory completion strobe
//   mem_data_in  read data, valid when mem_done = 1
//   mem_rd       memory read request (level)
//   mem_wr       memory write request (level)
//   mem_addr     memory address
//   mem_wdata    memory write data
//   stall_out    access outstanding; freeze upstream
//   rdata_out    load data to MEM/WB
//   err_out      sticky error flag
//   stall_cnt    saturating count of stall cycles
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_in,
    input  logic        wr_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        adv_in,
    input  logic        mem_done,
    input  logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        stall_out,
    output logic [15:0] rdata_out,
    output logic        err_out,
    output logic [15:0] stall_cnt
);

    // The wait counter only has to reach TIMEOUT.
    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    localparam logic [15:0] ERR_DATA = 16'hFFFF;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state;
    logic [15:0]       data_q;
    logic [15:0]       addr_q;
    logic [15:0]       wdata_q;
    logic              op_rd_q;      // latched op: 1 = read, 0 = write
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       stall_cnt_q;
    logic              err_q;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic req;
    logic bad;
    logic issue;

    assign req   = rd_in | wr_in;
    // Reads and writes together are contradictory; odd addresses are not
    // halfword aligned. Neither reaches the memory.
    assign bad   = (rd_in & wr_in) | (req & addr_in[0]);
    assign issue = (state == ST_IDLE) & req & ~bad;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    logic [1:0]  state_nxt;
    logic        stall_c;
    logic        rd_c;
    logic        wr_c;
    logic [15:0] addr_c;
    logic [15:0] wdata_c;
    logic [15:0] rdata_c;
    logic        complete;   // completion cycle (normal, error or forced)
    logic        load_data;  // read finished with mem_done: capture data
    logic        err_set;    // bad request or timeout

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold its value.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        addr_c    = 16'h0000;
        wdata_c   = 16'h0000;
        rdata_c   = data_q;
        complete  = 1'b0;
        load_data = 1'b0;
        err_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (bad) begin
                        // Rejected without touching the memory; the stage
                        // still completes so the pipeline keeps moving.
                        complete = 1'b1;
                        err_set  = 1'b1;
                        rdata_c  = ERR_DATA;
                    end else begin
                        // Issue straight from the pipeline register so a
                        // zero-wait memory finishes in this same cycle.
                        rd_c    = rd_in;
                        wr_c    = wr_in;
                        addr_c  = addr_in;
                        wdata_c = wdata_in;
                        if (mem_done) begin
                            complete = 1'b1;
                            if (rd_in) begin
                                rdata_c   = mem_data_in;
                                load_data = 1'b1;
                            end
                        end else begin
                            stall_c   = 1'b1;
                            state_nxt = ST_BUSY;
                        end
                    end
                end
            end

            ST_BUSY: begin
                if (mem_done) begin
                    // A done that coincides with the timeout still counts as
                    // a normal completion.
                    rd_c     = op_rd_q;
                    wr_c     = ~op_rd_q;
                    addr_c   = addr_q;
                    wdata_c  = wdata_q;
                    complete = 1'b1;
                    if (op_rd_q) begin
                        rdata_c   = mem_data_in;
                        load_data = 1'b1;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    // Forced completion: drop the request and report an error.
                    complete = 1'b1;
                    err_set  = 1'b1;
                    rdata_c  = ERR_DATA;
                end else begin
                    rd_c    = op_rd_q;
                    wr_c    = ~op_rd_q;
                    addr_c  = addr_q;
                    wdata_c = wdata_q;
                    stall_c = 1'b1;
                end
            end

            ST_DONE: begin
                // The access already finished but the pipeline has not moved
                // on; hold off so the same instruction is not issued again.
                if (adv_in) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (complete) begin
            state_nxt = adv_in ? ST_IDLE : ST_DONE;
        end
    end

    // Reset drops the request in the same cycle, abandoning any access.
    assign mem_rd    = rd_c & ~rst;
    assign mem_wr    = wr_c & ~rst;
    assign stall_out = stall_c & ~rst;
    assign mem_addr  = addr_c;
    assign mem_wdata = wdata_c;
    assign rdata_out = rdata_c;
    assign err_out   = err_q;
    assign stall_cnt = stall_cnt_q;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            data_q      <= 16'h0000;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            op_rd_q     <= 1'b0;
            wait_cnt    <= '0;
            stall_cnt_q <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (issue) begin
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
                op_rd_q <= rd_in;
            end

            // Counts stall cycles of the current access; the issue cycle is
            // the first one.
            if (stall_c) begin
                if (state == ST_IDLE) begin
                    wait_cnt <= WAIT_ONE;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_ONE;
                end
            end

            if (load_data) begin
                data_q <= mem_data_in;
            end else if (err_set) begin
                data_q <= ERR_DATA;
            end

            if (err_set) begin
                err_q <= 1'b1;
            end

            if (stall_c && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl with TIMEOUT = 4. Inputs change just after
// the falling edge; outputs are sampled 1 ns later, well before the next
// rising edge, so both combinational and registered values are stable.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_in;
    logic        wr_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        adv_in;
    logic        mem_done;
    logic [15:0] mem_data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        stall_out;
    logic [15:0] rdata_out;
    logic        err_out;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_in       (rd_in),
        .wr_in       (wr_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .adv_in      (adv_in),
        .mem_done    (mem_done),
        .mem_data_in (mem_data_in),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .stall_out   (stall_out),
        .rdata_out   (rdata_out),
        .err_out     (err_out),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        rd_in       = 1'b0;
        wr_in       = 1'b0;
        addr_in     = 16'h0000;
        wdata_in    = 16'h0000;
        adv_in      = 1'b1;
        mem_done    = 1'b0;
        mem_data_in = 16'h0000;
    endtask

    // One reset cycle, then idle inputs.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        rd_in   = 1'b1;
        addr_in = 16'h0010;
        #1;
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall_out); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_out); end
        total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL rst_stall_cnt: got %h want 0000", stall_cnt); end
        total++; if (rdata_out !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h want 0000", rdata_out); end
        total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL rst_idle_req: got rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
    endtask

    task automatic test_zero_wait_read();
        @(negedge clk);
        rd_in       = 1'b1;
        addr_in     = 16'h0010;
        mem_done    = 1'b1;
        mem_data_in = 16'hBEEF;
        #1;
        total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL zw_mem_rd: got %b want 1", mem_rd); end
        total++; if (mem_addr !== 16'h0010) begin bad++; $display("FAIL zw_addr: got %h want 0010", mem_addr); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL zw_stall: got %b want 0", stall_out); end
        total++; if (rdata_out !== 16'hBEEF) begin bad++; $display("FAIL zw_rdata: got %h want beef", rdata_out); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL zw_stall_cnt: got %h want 0000", stall_cnt); end
        total++; if (rdata_out !== 16'hBEEF) begin bad++; $display("FAIL zw_data_q: got %h want beef", rdata_out); end
    endtask

    task automatic test_write_wait3();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_in    = 1'b1;
            addr_in  = 16'h0020;
            wdata_in = 16'h1234;
            mem_done = (i == 3);
            #1;
            total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin bad++; $display("FAIL wr_req c%0d: got wr=%b rd=%b want 1 0", i, mem_wr, mem_rd); end
            total++; if (mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin bad++; $display("FAIL wr_bus c%0d: got %h/%h want 0020/1234", i, mem_addr, mem_wdata); end
            total++; if (stall_out !== (i < 3)) begin bad++; $display("FAIL wr_stall c%0d: got %b want %b", i, stall_out, (i < 3)); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (stall_cnt !== 16'h0003) begin bad++; $display("FAIL wr_stall_cnt: got %h want 0003", stall_cnt); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL wr_after: got %b want 0", mem_wr); end
        // A write leaves the previous load data in place.
        total++; if (rdata_out !== 16'hBEEF) begin bad++; $display("FAIL wr_data_q: got %h want beef", rdata_out); end
    endtask

    task automatic test_misaligned();
        do_reset();
        @(negedge clk);
        rd_in   = 1'b1;
        addr_in = 16'h0011;
        #1;
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL mis_mem_rd: got %b want 0", mem_rd); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", stall_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL mis_err_early: got %b want 0", err_out); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", err_out); end
        total++; if (rdata_out !== 16'hFFFF) begin bad++; $display("FAIL mis_rdata: got %h want ffff", rdata_out); end

        do_reset();
        @(negedge clk);
        rd_in   = 1'b1;
        wr_in   = 1'b1;
        addr_in = 16'h0040;
        #1;
        total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL both_req: got rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL both_err: got %b want 1", err_out); end
        total++; if (rdata_out !== 16'hFFFF) begin bad++; $display("FAIL both_rdata: got %h want ffff", rdata_out); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_in   = 1'b1;
            addr_in = 16'h0030;
            #1;
            total++; if (stall_out !== (i < 4)) begin bad++; $display("FAIL to_stall c%0d: got %b want %b", i, stall_out, (i < 4)); end
            total++; if (mem_rd !== (i < 4)) begin bad++; $display("FAIL to_mem_rd c%0d: got %b want %b", i, mem_rd, (i < 4)); end
        end
        total++; if (rdata_out !== 16'hFFFF) begin bad++; $display("FAIL to_rdata: got %h want ffff", rdata_out); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_out); end
        total++; if (stall_cnt !== 16'h0004) begin bad++; $display("FAIL to_stall_cnt: got %h want 0004", stall_cnt); end
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_in       = 1'b1;
            addr_in     = 16'h0032;
            mem_done    = (i == 4);
            mem_data_in = 16'h5A5A;
        end
        #1;
        total++; if (stall_out !== 1'b0 || mem_rd !== 1'b1) begin bad++; $display("FAIL dt_req: got stall=%b rd=%b want 0 1", stall_out, mem_rd); end
        total++; if (rdata_out !== 16'h5A5A) begin bad++; $display("FAIL dt_rdata: got %h want 5a5a", rdata_out); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL dt_err: got %b want 0", err_out); end
        total++; if (stall_cnt !== 16'h0004) begin bad++; $display("FAIL dt_stall_cnt: got %h want 0004", stall_cnt); end
    endtask

    task automatic test_done_hold();
        do_reset();
        @(negedge clk);
        rd_in       = 1'b1;
        addr_in     = 16'h0050;
        adv_in      = 1'b0;
        mem_done    = 1'b1;
        mem_data_in = 16'hCAFE;
        #1;
        total++; if (mem_rd !== 1'b1 || rdata_out !== 16'hCAFE) begin bad++; $display("FAIL hold_first: got rd=%b data=%h want 1 cafe", mem_rd, rdata_out); end
        // Pipeline held by another hazard: same instruction still presented,
        // and a stray done with other data must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_data_in = 16'h1111;
            adv_in      = (i == 2);
            #1;
            total++; if (mem_rd !== 1'b0 || stall_out !== 1'b0) begin bad++; $display("FAIL hold_req c%0d: got rd=%b stall=%b want 0 0", i, mem_rd, stall_out); end
            total++; if (rdata_out !== 16'hCAFE) begin bad++; $display("FAIL hold_rdata c%0d: got %h want cafe", i, rdata_out); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (mem_rd !== 1'b0 || rdata_out !== 16'hCAFE) begin bad++; $display("FAIL hold_after: got rd=%b data=%h want 0 cafe", mem_rd, rdata_out); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        // Set the error flag first so its clearing is visible.
        @(negedge clk);
        rd_in   = 1'b1;
        addr_in = 16'h0061;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_in   = 1'b1;
            addr_in = 16'h0060;
            rst     = (i == 2);
            #1;
            if (i == 1) begin
                total++; if (mem_rd !== 1'b1 || stall_out !== 1'b1) begin bad++; $display("FAIL rb_busy1: got rd=%b stall=%b want 1 1", mem_rd, stall_out); end
            end
        end
        total++; if (mem_rd !== 1'b0 || stall_out !== 1'b0) begin bad++; $display("FAIL rb_rst_cycle: got rd=%b stall=%b want 0 0", mem_rd, stall_out); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL rb_err: got %b want 0", err_out); end
        total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL rb_stall_cnt: got %h want 0000", stall_cnt); end
        total++; if (stall_out !== 1'b0 || mem_rd !== 1'b0) begin bad++; $display("FAIL rb_idle: got stall=%b rd=%b want 0 0", stall_out, mem_rd); end
        total++; if (rdata_out !== 16'h0000) begin bad++; $display("FAIL rb_rdata: got %h want 0000", rdata_out); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_wait_read();
        test_write_wait3();
        test_misaligned();
        test_timeout();
        test_done_at_timeout();
        test_done_hold();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
